gf2k_exp_seq: RTL and testbench



---
 rtl/gf2k_pkg.sv | 24 ++
 rtl/gf2k_mul_core.sv | 31 +++
 rtl/gf2k_exp_seq.sv | 109 ++++++++++
 tb/tb_gf2k_exp_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gf2k_pkg.sv
// rtl/gf2k_pkg.sv - shared FSM encoding, field constant and width helper for gf2k_exp_seq
package gf2k_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SQR  = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int GF_ONE = 1;

    // Never returns less than 1 so a one-bit exponent still gets a real index register.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gf2k_mul_core.sv
// rtl/gf2k_mul_core.sv - combinational GF(2^DEG) multiply with polynomial reduction
module gf2k_mul_core #(
    parameter int DEG = 5
) (
    input  logic [DEG:0]   poly,
    input  logic [DEG-1:0] a,
    input  logic [DEG-1:0] b,
    output logic [DEG-1:0] p
);

    localparam int PW = 2 * DEG - 1;

    logic [PW-1:0] prod;

    // Full carry-less product first, then fold the high bits down from the top.
    always_comb begin
        prod = '0;
        for (int i = 0; i < DEG; i++) begin
            if (b[i]) begin
                prod = prod ^ (PW'(a) << i);
            end
        end
        for (int j = PW - 1; j >= DEG; j--) begin
            if (prod[j]) begin
                prod = prod ^ (PW'(poly) << (j - DEG));
            end
        end
        p = prod[DEG-1:0];
    end

endmodule

// File: rtl/gf2k_exp_seq.sv
// rtl/gf2k_exp_seq.sv - sequential GF(2^DEG) square-and-multiply exponentiator; option GF2K_EXP_SKIP_LZ_EN
module gf2k_exp_seq
    import gf2k_pkg::*;
#(
    parameter int DEG   = 5,
    parameter int EXP_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [DEG:0]     POLY,
    input  logic [DEG-1:0]   BASE,
    input  logic [EXP_W-1:0] EXP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [DEG-1:0]   RESULT,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int IW = clog2(EXP_W);

    logic [1:0]       state;
    logic [DEG:0]     poly_q;
    logic [DEG-1:0]   base_q;
    logic [EXP_W-1:0] exp_q;
    logic [DEG-1:0]   acc;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    start_idx;
    logic [DEG-1:0]   mul_b;
    logic [DEG-1:0]   mul_p;

    // One multiplier serves both steps: squaring feeds acc on both sides.
    assign mul_b = (state == ST_MUL) ? base_q : acc;

    gf2k_mul_core #(
        .DEG(DEG)
    ) u_mul (
        .poly(poly_q),
        .a   (acc),
        .b   (mul_b),
        .p   (mul_p)
    );

`ifdef GF2K_EXP_SKIP_LZ_EN
    always_comb begin
        start_idx = '0;
        for (int i = 0; i < EXP_W; i++) begin
            if (EXP[i]) begin
                start_idx = IW'(i);
            end
        end
    end
`else
    assign start_idx = IW'(EXP_W - 1);
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            poly_q <= '0;
            base_q <= '0;
            exp_q  <= '0;
            acc    <= '0;
            idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        poly_q <= POLY;
                        base_q <= BASE;
                        exp_q  <= EXP;
                        acc    <= DEG'(GF_ONE);
                        idx    <= start_idx;
                        state  <= ST_SQR;
                    end
                end
                ST_SQR: begin
                    acc <= mul_p;
                    if (exp_q[idx]) begin
                        state <= ST_MUL;
                    end else if (idx == '0) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_MUL: begin
                    acc <= mul_p;
                    if (idx == '0) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= ST_SQR;
                    end
                end
                default: begin
                    if (OUT_READY) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign IN_READY  = (state == ST_IDLE);
    assign OUT_VALID = (state == ST_DONE);
    assign RESULT    = acc;

endmodule

// File: tb/tb_gf2k_exp_seq.sv
// tb/tb_gf2k_exp_seq.sv - directed and randomized self-checking bench for gf2k_exp_seq
module tb_gf2k_exp_seq;

    localparam logic [5:0] P = 6'b100101;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [5:0] POLY;
    logic [4:0] BASE;
    logic [7:0] EXP;
    logic       IN_VALID;
    logic       IN_READY;
    logic [4:0] RESULT;
    logic       OUT_VALID;
    logic       OUT_READY;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    gf2k_exp_seq #(
        .DEG  (5),
        .EXP_W(8)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .POLY     (POLY),
        .BASE     (BASE),
        .EXP      (EXP),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .RESULT   (RESULT),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] e);
        int m;
        m = 7;
`ifdef GF2K_EXP_SKIP_LZ_EN
        m = 0;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) m = i;
        end
`endif
        return m + 1 + $countones(e);
    endfunction

    // Shift-and-add multiply reducing one bit at a time (x^5 = x^2 + 1).
    function automatic logic [4:0] xmul(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] r;
        logic [4:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < 5; i++) begin
            if (b[i]) r = r ^ t;
            t = t[4] ? ({t[3:0], 1'b0} ^ P[4:0]) : {t[3:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [4:0] gexp(input logic [4:0] b, input logic [7:0] e);
        logic [4:0] r;
        r = 5'd1;
        for (int k = 0; k < int'(e); k++) r = xmul(r, b);
        return r;
    endfunction

    task automatic start(input logic [4:0] b, input logic [7:0] e);
        @(negedge CLK);
        POLY = P;
        BASE = b;
        EXP = e;
        IN_VALID = 1'b1;
        chk("in_ready_before_accept", 32'(IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (OUT_VALID !== 1'b1 && n < 300) begin
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic take_result;
        @(negedge CLK);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        chk("idle_after_take", 32'(IN_READY), 32'd1);
        chk("out_valid_after_take", 32'(OUT_VALID), 32'd0);
    endtask

    task automatic op(input string tag, input logic [4:0] b, input logic [7:0] e, input logic [4:0] expv);
        int n;
        start(b, e);
        wait_done(n);
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat(e)));
        chk({tag, "_result"}, 32'(RESULT), 32'(expv));
        take_result();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [4:0] held;
        logic [4:0] rb;
        logic [7:0] re;

        RST_N = 1'b0;
        POLY = P;
        BASE = '0;
        EXP = '0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_in_ready", 32'(IN_READY), 32'd1);
        chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
        chk("reset_result", 32'(RESULT), 32'd0);
        RST_N = 1'b1;

        op("x5", 5'd2, 8'd5, 5'd5);
        op("x6", 5'd2, 8'd6, 5'd10);
        op("x31", 5'd2, 8'd31, 5'd1);
        op("x255", 5'd2, 8'd255, 5'd20);
        op("zero_pow_zero", 5'd0, 8'd0, 5'd1);
        op("b17_pow_zero", 5'd17, 8'd0, 5'd1);
        op("zero_pow3", 5'd0, 8'd3, 5'd0);
        op("one_pow200", 5'd1, 8'd200, 5'd1);

        // Consumer stalls in DONE while new requests knock.
        start(5'd2, 8'd5);
        wait_done(n);
        chk("hold_latency", 32'(n), 32'(exp_lat(8'd5)));
        held = RESULT;
        chk("hold_result", 32'(held), 32'd5);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            IN_VALID = 1'b1;
            BASE = 5'd7;
            EXP = 8'd1;
            @(posedge CLK);
            #1;
            chk("hold_result_stable", 32'(RESULT), 32'(held));
            chk("hold_out_valid", 32'(OUT_VALID), 32'd1);
            chk("hold_in_ready_low", 32'(IN_READY), 32'd0);
        end
        IN_VALID = 1'b0;
        take_result();
        op("after_hold", 5'd2, 8'd6, 5'd10);

        // Reset lands mid-scan of a long exponent.
        start(5'd2, 8'hFF);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort_in_ready", 32'(IN_READY), 32'd1);
        chk("abort_out_valid", 32'(OUT_VALID), 32'd0);
        chk("abort_result", 32'(RESULT), 32'd0);
        RST_N = 1'b1;
        op("after_abort", 5'd2, 8'd31, 5'd1);

        for (int k = 0; k < 150; k++) begin
            rb = 5'($urandom_range(0, 31));
            re = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            start(rb, re);
            wait_done(n);
            chk("rand_latency", 32'(n), 32'(exp_lat(re)));
            chk("rand_result", 32'(RESULT), 32'(gexp(rb, re)));
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK);
                #1;
            end
            take_result();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
